speed_ramp_controller: RTL and testbench
========================================

Name: speed_ramp_controller

Overview:
Parametrised drive-train controller for the car dashboard. It consumes the ADC response stream and latches the pedal and brake channels. It runs a gear state machine with interlocks, ramps vehicle speed toward a pedal-derived target at rate-limited steps, and drives the motor direction outputs. It also produces a sequential BCD (binary-coded decimal) speed readout for the 7-segment decoders.

Parameters:
DATA_W, 12, ADC sample width
SPEED_W, 13, speed register width (units 0.1 km/h)
MAX_SPEED, 2250, speed at full pedal (225.0 km/h)
PEDAL_CH, 1, ADC channel carrying pedal
BRAKE_CH, 2, ADC channel carrying brake
BRAKE_THRESH, 2048, brake sample at or above this counts as brake applied
TICK_DIV, 500000, sys_clk cycles per speed-update tick
ACCEL_STEP, 2, speed increment per tick
DECEL_STEP, 1, release decrement per tick
COAST_STEP, 1, neutral decrement per tick
BRAKE_STEP, 8, brake decrement per tick
MIN_MOVE, 10, speed at or above which the vehicle counts as moving

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
adc_valid  in  1  ADC response valid
adc_channel  in  5  ADC response channel
adc_data  in  DATA_W  ADC response sample
gear_req  in  2  requested gear: 00 neutral, 01 reverse, 10 drive, 11 park
gear_active  out  2  accepted gear, same encoding
speed  out  SPEED_W  current speed
motor_fwd  out  1  forward drive enable
motor_rev  out  1  reverse drive enable
led_bar  out  10  speed[SPEED_W-1 -: 10]
bcd  out  16  four BCD digits of speed, thousands in [15:12]
bcd_valid  out  1  one-cycle pulse when bcd updates

Behaviour:
- Reset (async, asserted on rising edge of reset):
  - speed, pedal, brake latch, tick counter, bcd: 0
  - gear_active: park (11)
  - motor_fwd, motor_rev, bcd_valid: 0
  - any BCD conversion in progress is aborted
- Sample capture:
  - On adc_valid, adc_channel==PEDAL_CH: latch adc_data into pedal.
  - On adc_valid, adc_channel==BRAKE_CH: brake_on <= (adc_data >= BRAKE_THRESH).
  - Other channels: ignored.
- Target: target = (pedal * MAX_SPEED) >> DATA_W, floor division, computed combinationally from the latched pedal.
- Tick counter:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick asserts for one cycle when count == TICK_DIV-1.
- Gear FSM (states PARK, NEUTRAL, DRIVE, REVERSE), evaluated every cycle while gear_req != gear_active:
  - Neutral request: always accepted.
  - Drive or reverse request: accepted only if speed < MIN_MOVE.
  - Park request: accepted only if speed == 0.
  - Rejected requests: no state change. They are re-evaluated each cycle, so a held request is accepted as soon as its condition holds.
- Speed update, on tick only, using gear_active and latches as registered before that edge:
  - DRIVE or REVERSE:
    - brake_on: speed - BRAKE_STEP, floor 0.
    - else speed < target: speed + ACCEL_STEP, capped at target.
    - else speed > target: speed - DECEL_STEP, floored at target.
  - NEUTRAL: brake_on subtracts BRAKE_STEP, else COAST_STEP; floor 0.
  - PARK: speed <= 0.
  - All arithmetic is unsigned. Underflow is forbidden and saturates at 0.
  - speed never exceeds MAX_SPEED.
- Simultaneous events:
  - A sample arriving on the tick cycle is used from the next tick.
  - A gear acceptance on the tick cycle affects the next tick.
- Motor outputs, registered:
  - motor_fwd = (gear_active == DRIVE) && speed >= MIN_MOVE
  - motor_rev = (gear_active == REVERSE) && speed >= MIN_MOVE
  - motor_fwd and motor_rev are never both 1.
- BCD conversion:
  - Each tick starts a sequential shift-add-3 (double-dabble) conversion of the post-update speed.
  - Takes SPEED_W shift cycles.
  - bcd and bcd_valid are registered on the cycle after the final shift, giving latency SPEED_W+1 cycles from tick.
  - A tick arriving while busy is ignored; busy cannot occur when TICK_DIV > SPEED_W+1.
  - bcd holds its value between updates.

Test Plan:
- Bench uses TICK_DIV=4.
- Reset mid-ramp: assert reset with speed=500 → next cycle speed=0, gear_active=11, bcd=0, motors 0.
- Pedal ramp: gear_req=10 from park at speed 0; pedal sample 4095 on ch1; no brake → gear_active=10 next cycle; speed +2 per tick up to target 2249, then holds; motor_fwd=1 once speed>=10.
- Brake saturation: speed=13, brake sample 3000 on ch2 → speed 5 after one tick, 0 after the next; motor_fwd falls when speed<10.
- Interlock: speed=800 in drive, gear_req=01 → gear_active stays 10. Request to 00 → neutral accepted, coasts −1/tick. Re-request 01 → accepted on the cycle speed reaches 9.
- BCD: speed reaches 1234 → bcd=16'h1234, bcd_valid pulses exactly 14 cycles after the tick.
- Channel filter: adc_valid with channel 3, data 4095 → target unchanged.

Source files
------------

// File: rtl/speed_ramp_controller.sv
// Drive-train controller: latches pedal/brake from the ADC stream, runs the gear
// interlock FSM, ramps speed on a divided tick and produces a sequential BCD readout.
module speed_ramp_controller #(
  parameter int DATA_W       = 12,
  parameter int SPEED_W      = 13,
  parameter int MAX_SPEED    = 2250,
  parameter int PEDAL_CH     = 1,
  parameter int BRAKE_CH     = 2,
  parameter int BRAKE_THRESH = 2048,
  parameter int TICK_DIV     = 500000,
  parameter int ACCEL_STEP   = 2,
  parameter int DECEL_STEP   = 1,
  parameter int COAST_STEP   = 1,
  parameter int BRAKE_STEP   = 8,
  parameter int MIN_MOVE     = 10
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               adc_valid,
  input  logic [4:0]         adc_channel,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic [1:0]         gear_req,
  output logic [1:0]         gear_active,
  output logic [SPEED_W-1:0] speed,
  output logic               motor_fwd,
  output logic               motor_rev,
  output logic [9:0]         led_bar,
  output logic [15:0]        bcd,
  output logic               bcd_valid
);

  localparam logic [1:0] GEAR_NEUTRAL = 2'b00;
  localparam logic [1:0] GEAR_REVERSE = 2'b01;
  localparam logic [1:0] GEAR_DRIVE   = 2'b10;
  localparam logic [1:0] GEAR_PARK    = 2'b11;

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PROD_W = DATA_W + SPEED_W;
  localparam int BCNT_W = $clog2(SPEED_W + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST      = TICK_W'(TICK_DIV - 1);
  localparam logic [PROD_W-1:0]  MAX_SPEED_P    = PROD_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] MAX_SPEED_S    = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] ACCEL_S        = SPEED_W'(ACCEL_STEP);
  localparam logic [SPEED_W-1:0] DECEL_S        = SPEED_W'(DECEL_STEP);
  localparam logic [SPEED_W-1:0] COAST_S        = SPEED_W'(COAST_STEP);
  localparam logic [SPEED_W-1:0] BRAKE_S        = SPEED_W'(BRAKE_STEP);
  localparam logic [SPEED_W-1:0] MIN_MOVE_S     = SPEED_W'(MIN_MOVE);
  localparam logic [4:0]         PEDAL_CH_C     = 5'(PEDAL_CH);
  localparam logic [4:0]         BRAKE_CH_C     = 5'(BRAKE_CH);
  localparam logic [DATA_W-1:0]  BRAKE_THRESH_C = DATA_W'(BRAKE_THRESH);
  localparam logic [BCNT_W-1:0]  BCNT_LAST      = BCNT_W'(SPEED_W);

  function automatic logic [SPEED_W-1:0] sat_sub(input logic [SPEED_W-1:0] a,
                                                 input logic [SPEED_W-1:0] b);
    return (a > b) ? (a - b) : {SPEED_W{1'b0}};
  endfunction

  function automatic logic [15:0] dabble_adjust(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  logic [DATA_W-1:0]  r_pedal;
  logic               r_brake_on;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic [1:0]         r_gear;
  logic [SPEED_W-1:0] r_speed;
  logic               r_motor_fwd;
  logic               r_motor_rev;
  logic               r_bcd_busy;
  logic [BCNT_W-1:0]  r_bcd_cnt;
  logic [SPEED_W-1:0] r_bcd_bin;
  logic [15:0]        r_bcd_work;
  logic [15:0]        r_bcd;
  logic               r_bcd_valid;

  logic               w_tick;
  logic [PROD_W-1:0]  w_prod;
  logic [SPEED_W-1:0] w_target;
  logic [SPEED_W:0]   w_sum;
  logic [SPEED_W-1:0] w_dec;
  logic [SPEED_W-1:0] w_speed_calc;
  logic [SPEED_W-1:0] w_speed_nxt;
  logic [1:0]         w_gear_nxt;
  logic               w_fwd_nxt;
  logic               w_rev_nxt;
  logic [15:0]        w_dabble;

  assign w_tick   = (r_tick_cnt == TICK_LAST);
  assign w_prod   = {{SPEED_W{1'b0}}, r_pedal} * MAX_SPEED_P;
  assign w_target = SPEED_W'(w_prod >> DATA_W);
  assign w_sum    = {1'b0, r_speed} + {1'b0, ACCEL_S};
  assign w_dec    = sat_sub(r_speed, DECEL_S);
  assign w_dabble = dabble_adjust(r_bcd_work);

  // Only the pedal and brake channels touch the latches; everything else is dropped
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_pedal    <= {DATA_W{1'b0}};
      r_brake_on <= 1'b0;
    end else if (adc_valid) begin
      if (adc_channel == PEDAL_CH_C) r_pedal <= adc_data;
      else if (adc_channel == BRAKE_CH_C) r_brake_on <= (adc_data >= BRAKE_THRESH_C);
    end
  end

  always_comb begin
    w_speed_calc = r_speed;
    case (r_gear)
      GEAR_DRIVE, GEAR_REVERSE: begin
        if (r_brake_on) begin
          w_speed_calc = sat_sub(r_speed, BRAKE_S);
        end else if (r_speed < w_target) begin
          if (w_sum >= {1'b0, w_target}) w_speed_calc = w_target;
          else w_speed_calc = w_sum[SPEED_W-1:0];
        end else if (r_speed > w_target) begin
          if (w_dec < w_target) w_speed_calc = w_target;
          else w_speed_calc = w_dec;
        end else begin
          w_speed_calc = r_speed;
        end
      end
      GEAR_NEUTRAL: begin
        if (r_brake_on) w_speed_calc = sat_sub(r_speed, BRAKE_S);
        else w_speed_calc = sat_sub(r_speed, COAST_S);
      end
      GEAR_PARK: w_speed_calc = {SPEED_W{1'b0}};
      default:   w_speed_calc = {SPEED_W{1'b0}};
    endcase
  end

  always_comb begin
    w_speed_nxt = r_speed;
    if (!w_tick) w_speed_nxt = r_speed;
    else if (w_speed_calc > MAX_SPEED_S) w_speed_nxt = MAX_SPEED_S;
    else w_speed_nxt = w_speed_calc;
  end

  // Gear interlock: a held request is re-tried every cycle against the current speed
  always_comb begin
    w_gear_nxt = r_gear;
    if (gear_req != r_gear) begin
      case (gear_req)
        GEAR_NEUTRAL: w_gear_nxt = GEAR_NEUTRAL;
        GEAR_DRIVE, GEAR_REVERSE: begin
          if (r_speed < MIN_MOVE_S) w_gear_nxt = gear_req;
          else w_gear_nxt = r_gear;
        end
        GEAR_PARK: begin
          if (r_speed == {SPEED_W{1'b0}}) w_gear_nxt = GEAR_PARK;
          else w_gear_nxt = r_gear;
        end
        default: w_gear_nxt = r_gear;
      endcase
    end else begin
      w_gear_nxt = r_gear;
    end
  end

  // Motor enables are decoded from next-state values so they line up with gear/speed
  assign w_fwd_nxt = (w_gear_nxt == GEAR_DRIVE)   && (w_speed_nxt >= MIN_MOVE_S);
  assign w_rev_nxt = (w_gear_nxt == GEAR_REVERSE) && (w_speed_nxt >= MIN_MOVE_S);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt  <= {TICK_W{1'b0}};
      r_gear      <= GEAR_PARK;
      r_speed     <= {SPEED_W{1'b0}};
      r_motor_fwd <= 1'b0;
      r_motor_rev <= 1'b0;
    end else begin
      r_tick_cnt  <= w_tick ? {TICK_W{1'b0}} : (r_tick_cnt + TICK_W'(1));
      r_gear      <= w_gear_nxt;
      r_speed     <= w_speed_nxt;
      r_motor_fwd <= w_fwd_nxt;
      r_motor_rev <= w_rev_nxt;
    end
  end

  // Double-dabble: SPEED_W adjust+shift steps, then one cycle to publish the digits
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_bcd_busy  <= 1'b0;
      r_bcd_cnt   <= {BCNT_W{1'b0}};
      r_bcd_bin   <= {SPEED_W{1'b0}};
      r_bcd_work  <= 16'h0000;
      r_bcd       <= 16'h0000;
      r_bcd_valid <= 1'b0;
    end else begin
      r_bcd_valid <= 1'b0;
      if (r_bcd_busy) begin
        if (r_bcd_cnt == BCNT_LAST) begin
          r_bcd       <= r_bcd_work;
          r_bcd_valid <= 1'b1;
          r_bcd_busy  <= 1'b0;
        end else begin
          {r_bcd_work, r_bcd_bin} <= {w_dabble, r_bcd_bin} << 1;
          r_bcd_cnt               <= r_bcd_cnt + BCNT_W'(1);
        end
      end else if (w_tick) begin
        r_bcd_bin  <= w_speed_nxt;
        r_bcd_work <= 16'h0000;
        r_bcd_cnt  <= {BCNT_W{1'b0}};
        r_bcd_busy <= 1'b1;
      end
    end
  end

  assign gear_active = r_gear;
  assign speed       = r_speed;
  assign motor_fwd   = r_motor_fwd;
  assign motor_rev   = r_motor_rev;
  assign led_bar     = r_speed[SPEED_W-1 -: 10];
  assign bcd         = r_bcd;
  assign bcd_valid   = r_bcd_valid;

endmodule

// File: tb/tb_speed_ramp_controller.sv
// Directed bench for speed_ramp_controller with a 4-cycle tick: reset, ramping,
// braking, gear interlocks, channel filtering and BCD latency.
module tb_speed_ramp_controller;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        adc_valid;
  logic [4:0]  adc_channel;
  logic [11:0] adc_data;
  logic [1:0]  gear_req;
  logic [1:0]  gear_active;
  logic [12:0] speed;
  logic        motor_fwd;
  logic        motor_rev;
  logic [9:0]  led_bar;
  logic [15:0] bcd;
  logic        bcd_valid;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int guard;
  int ramp_exp [8] = '{2, 4, 6, 8, 10, 12, 13, 13};

  speed_ramp_controller #(.TICK_DIV(4)) dut (
    .sys_clk(sys_clk), .reset(reset), .adc_valid(adc_valid),
    .adc_channel(adc_channel), .adc_data(adc_data), .gear_req(gear_req),
    .gear_active(gear_active), .speed(speed), .motor_fwd(motor_fwd),
    .motor_rev(motor_rev), .led_bar(led_bar), .bcd(bcd), .bcd_valid(bcd_valid)
  );

  always #5 sys_clk = ~sys_clk;

  // Edge count since reset release; tick edges are the multiples of 4
  always @(posedge sys_clk or posedge reset) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_tick();
    cycle();
    while (cyc % 4 != 0) cycle();
  endtask

  task automatic adc(input logic [4:0] ch, input logic [11:0] d);
    adc_valid   = 1'b1;
    adc_channel = ch;
    adc_data    = d;
    cycle();
    adc_valid   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; adc_valid = 1'b0; adc_channel = 5'd0; adc_data = 12'd0; gear_req = 2'b11;
    repeat (3) cycle();
    check("rst_speed", speed, 0);
    check("rst_gear", gear_active, 2'b11);
    check("rst_fwd", motor_fwd, 0);
    check("rst_rev", motor_rev, 0);
    check("rst_bcd", bcd, 0);
    check("rst_bcd_valid", bcd_valid, 0);
    check("rst_led", led_bar, 0);

    // Drive from park, pedal 24 -> target 13; channel 3 full-scale must be ignored
    reset = 1'b0;
    gear_req = 2'b10;
    adc(5'd1, 12'd24);
    check("gear_drive_accept", gear_active, 2'b10);
    adc(5'd3, 12'd4095);
    for (int i = 0; i < 8; i++) begin
      wait_tick();
      check("ramp_speed", speed, ramp_exp[i]);
      check("ramp_fwd", motor_fwd, ramp_exp[i] >= 10);
    end
    check("ramp_rev", motor_rev, 0);

    // Brake from 13: 5 then saturate at 0; park held off until standstill
    adc(5'd2, 12'd3000);
    wait_tick();
    check("brake_speed_5", speed, 5);
    check("brake_fwd_low", motor_fwd, 0);
    gear_req = 2'b11;
    cycle();
    check("park_rejected", gear_active, 2'b10);
    wait_tick();
    check("brake_speed_0", speed, 0);
    check("park_still_rejected", gear_active, 2'b10);
    cycle();
    check("park_accepted", gear_active, 2'b11);
    gear_req = 2'b10;
    adc(5'd2, 12'd100);
    check("drive_again", gear_active, 2'b10);
    adc(5'd1, 12'd1457);
    wait_tick();
    check("ramp800_first", speed, 2);
    repeat (399) wait_tick();
    check("ramp800_top", speed, 800);
    check("ramp800_led", led_bar, 100);
    check("ramp800_fwd", motor_fwd, 1);
    wait_tick();
    check("ramp800_hold", speed, 800);

    // Interlock: reverse refused while moving, neutral always taken
    gear_req = 2'b01;
    cycle();
    check("rev_rejected_a", gear_active, 2'b10);
    cycle();
    check("rev_rejected_b", gear_active, 2'b10);
    gear_req = 2'b00;
    cycle();
    check("neutral_accept", gear_active, 2'b00);
    check("neutral_fwd_off", motor_fwd, 0);
    gear_req = 2'b01;
    wait_tick();
    check("coast_first", speed, 799);
    repeat (789) wait_tick();
    check("coast_10", speed, 10);
    check("coast_10_gear", gear_active, 2'b00);
    wait_tick();
    check("coast_9", speed, 9);
    check("coast_9_gear", gear_active, 2'b00);
    cycle();
    check("rev_accept", gear_active, 2'b01);
    check("rev_motor_slow", motor_rev, 0);
    wait_tick();
    check("rev_speed_11", speed, 11);
    check("rev_motor_on", motor_rev, 1);
    check("rev_fwd_off", motor_fwd, 0);

    // Reverse toward target 500, then a one-step release and re-cap
    adc(5'd1, 12'd911);
    repeat (245) wait_tick();
    check("rev500", speed, 500);
    check("rev500_led", led_bar, 62);
    adc(5'd1, 12'd910);
    wait_tick();
    check("decel_499", speed, 499);
    wait_tick();
    check("decel_hold", speed, 499);
    adc(5'd1, 12'd911);
    wait_tick();
    check("accel_cap_500", speed, 500);

    reset = 1'b1;
    cycle();
    check("rst2_speed", speed, 0);
    check("rst2_gear", gear_active, 2'b11);
    check("rst2_rev", motor_rev, 0);
    check("rst2_bcd", bcd, 0);
    check("rst2_bcd_valid", bcd_valid, 0);

    // Ramp to 1234 and measure BCD latency from a conversion-starting tick
    reset = 1'b0;
    gear_req = 2'b10;
    adc(5'd1, 12'd2247);
    check("gear_drive_2", gear_active, 2'b10);
    repeat (617) wait_tick();
    check("ramp1234", speed, 1234);
    check("ramp1234_led", led_bar, 154);
    guard = 0;
    while (!bcd_valid && guard < 40) begin
      cycle();
      guard++;
    end
    check("bcd_pulse_seen", bcd_valid, 1);
    wait_tick();
    for (int i = 1; i <= 15; i++) begin
      cycle();
      check("bcd_valid_timing", bcd_valid, i == 14);
      if (i >= 14) check("bcd_value", bcd, 16'h1234);
    end
    repeat (3) cycle();
    check("bcd_hold", bcd, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
